display_scan_ctrl: RTL and testbench

Time-multiplexes four 8-bit segment patterns onto the shared 4-digit, 8-segment display bus. It scans the digits in a fixed order, inserts dead-time blanking between digits to suppress ghosting, and applies per-frame brightness PWM. It also double-buffers digit contents behind a valid/ready write port, so the active frame changes only at a frame boundary. It sits between the counter/display pattern sources and the board pins, replacing ad-hoc scan logic in the top level.

---
 rtl/seg_pkg.sv | 10 +
 rtl/slot_timer.sv | 34 +++
 rtl/display_scan_ctrl.sv | 116 +++++++++++
 tb/tb_display_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed segment display scan path.
package seg_pkg;
  localparam int NUM_DIGITS = 4;

  typedef logic [7:0] seg_t;

  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} scan_state_t;

  localparam seg_t SEG_OFF = 8'h00;
endpackage

// File: rtl/slot_timer.sv
// Digit-slot timing: cycle counter inside a slot and the digit index it belongs to.
module slot_timer
  import seg_pkg::*;
#(
  parameter int SLOT_CYCLES = 100,
  parameter int CW          = $clog2(SLOT_CYCLES)
) (
  input  logic          clkIn,
  input  logic          resetIn,
  input  logic          run,
  output logic [CW-1:0] slot_cnt,
  output logic [1:0]    dig,
  output logic          slot_end,
  output logic          frame_wrap
);
  assign slot_end   = (slot_cnt == CW'(SLOT_CYCLES - 1));
  assign frame_wrap = slot_end && (dig == 2'(NUM_DIGITS - 1));

  // Held at digit 0 / cycle 0 whenever the scanner is idle so a new frame starts clean.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      slot_cnt <= '0;
      dig      <= '0;
    end else if (!run) begin
      slot_cnt <= '0;
      dig      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      dig      <= dig + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed segment driver: dead-time blanking, per-frame brightness PWM,
// and a double-buffered write port whose contents go live only at a frame boundary.
module display_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQUENCY = 27000000,
  parameter int FRAME_HZ      = 250,
  parameter int BLANK_CYCLES  = 16,
  parameter int BRIGHT_WIDTH  = 4
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    enableIn,
  input  logic [BRIGHT_WIDTH-1:0] brightnessIn,
  input  logic                    wrValidIn,
  output logic                    wrReadyOut,
  input  logic [1:0]              wrIndexIn,
  input  seg_t                    wrDataIn,
  input  logic                    commitIn,
  output logic                    commitPendingOut,
  output logic                    frameStartOut,
  output logic [NUM_DIGITS-1:0]   digitEnableOut,
  output seg_t                    segmentEnableOut
);
  localparam int SLOT_CYCLES = CLK_FREQUENCY / (FRAME_HZ * NUM_DIGITS);
  // STEP must be >= 1 or the lowest brightness code would never light a digit.
  localparam int STEP        = (SLOT_CYCLES - BLANK_CYCLES) >> BRIGHT_WIDTH;
  localparam int CW          = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t                 state;
  seg_t [NUM_DIGITS-1:0]       shadow, active;
  logic [CW-1:0]               slot_cnt, on_last;
  logic [1:0]                  dig;
  logic                        slot_end, frame_wrap, run, frame_go, swap, accept;
  logic [NUM_DIGITS-1:0]       dig_1h;

  // Last slot cycle of the ON phase; ends up at the slot end for the top code.
  function automatic logic [CW-1:0] on_last_of(input logic [BRIGHT_WIDTH-1:0] code);
    return CW'(BLANK_CYCLES + STEP * (int'(code) + 1) - 1);
  endfunction

  assign run      = enableIn && (state != IDLE);
  assign frame_go = enableIn && ((state == IDLE) || frame_wrap);
  assign swap     = commitPendingOut && ((state == IDLE) || frame_go);
  assign accept   = wrValidIn && wrReadyOut;
  assign dig_1h   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig;

  slot_timer #(.SLOT_CYCLES(SLOT_CYCLES), .CW(CW)) u_timer (
    .clkIn      (clkIn),
    .resetIn    (resetIn),
    .run        (run),
    .slot_cnt   (slot_cnt),
    .dig        (dig),
    .slot_end   (slot_end),
    .frame_wrap (frame_wrap)
  );

  // Writes are only possible while no commit is pending, so a swap never races a write.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      shadow           <= '0;
      active           <= '0;
      commitPendingOut <= 1'b0;
      wrReadyOut       <= 1'b1;
    end else begin
      if (accept) shadow[wrIndexIn] <= wrDataIn;
      if (swap) begin
        active           <= shadow;
        commitPendingOut <= 1'b0;
        wrReadyOut       <= 1'b1;
      end else if (commitIn) begin
        commitPendingOut <= 1'b1;
        wrReadyOut       <= 1'b0;
      end
    end
  end

  // Outputs are set from the state being entered so they line up with it cycle for cycle.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state            <= IDLE;
      frameStartOut    <= 1'b0;
      digitEnableOut   <= '0;
      segmentEnableOut <= SEG_OFF;
      on_last          <= '0;
    end else begin
      frameStartOut    <= frame_go;
      digitEnableOut   <= '0;
      segmentEnableOut <= SEG_OFF;
      if (frame_go) on_last <= on_last_of(brightnessIn);
      if (!enableIn) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:  state <= BLANK;
          BLANK: if (slot_cnt == BLANK_LAST) begin
                   state            <= ON;
                   digitEnableOut   <= dig_1h;
                   segmentEnableOut <= active[dig];
                 end
          ON:    if (slot_end) begin
                   state <= BLANK;
                 end else if (slot_cnt == on_last) begin
                   state <= OFF;
                 end else begin
                   digitEnableOut   <= dig_1h;
                   segmentEnableOut <= active[dig];
                 end
          OFF:   if (slot_end) state <= BLANK;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised and directed checks of display_scan_ctrl against a frame-time reference model.
module tb_display_scan_ctrl;
  localparam int SLOT  = 100;
  localparam int FRAME = 400;
  localparam int BLANK = 4;
  localparam int STEP  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, wr_valid = 1'b0, commit = 1'b0;
  logic [3:0] bright = '0;
  logic [1:0] wr_idx = '0;
  logic [7:0] wr_data = '0;
  logic       wrReadyOut, commitPendingOut, frameStartOut;
  logic [3:0] digitEnableOut;
  logic [7:0] segmentEnableOut;

  int checks = 0, errors = 0;

  // reference model: time since frame start plus the two digit buffers
  bit         m_run, m_pend;
  int         m_t, m_on_len;
  logic [7:0] m_shadow[4], m_active[4];
  logic [3:0] e_dig;
  logic [7:0] e_seg;
  logic       e_fs;

  // per-window observations
  int          f_bad, f_fs, f_gap_bad, f_on[4], f_on_tot;
  logic [7:0]  f_seg[4], f_seg_or;
  logic [14:0] f_got, f_exp;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .CLK_FREQUENCY(4000), .FRAME_HZ(10), .BLANK_CYCLES(4), .BRIGHT_WIDTH(4)
  ) dut (
    .clkIn(clk), .resetIn(rst_n), .enableIn(en), .brightnessIn(bright),
    .wrValidIn(wr_valid), .wrReadyOut(wrReadyOut), .wrIndexIn(wr_idx), .wrDataIn(wr_data),
    .commitIn(commit), .commitPendingOut(commitPendingOut), .frameStartOut(frameStartOut),
    .digitEnableOut(digitEnableOut), .segmentEnableOut(segmentEnableOut)
  );

  function automatic logic [14:0] dut_vec();
    return {digitEnableOut, segmentEnableOut, frameStartOut, commitPendingOut, wrReadyOut};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {e_dig, e_seg, e_fs, m_pend, !m_pend};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_t = 0; m_on_len = 0;
    for (int i = 0; i < 4; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    e_dig = '0; e_seg = '0; e_fs = 1'b0;
  endtask

  // one clock: advance the model on the rising edge, return at the falling edge
  task automatic tick();
    bit was_idle, sw, acc;
    int c, d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      was_idle = !m_run; sw = 0; acc = wr_valid && !m_pend;
      if (!en) m_run = 0;
      else begin
        if (!m_run) begin m_run = 1; m_t = 0; end
        else m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin m_on_len = STEP * (int'(bright) + 1); sw = m_pend; end
      end
      if (was_idle && m_pend) sw = 1;
      if (acc) m_shadow[wr_idx] = wr_data;
      if (sw) begin
        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
      end else if (commit) m_pend = 1;
    end
    c = m_t % SLOT; d = m_t / SLOT;
    e_fs = m_run && (m_t == 0);
    if (m_run && c >= BLANK && c < BLANK + m_on_len) begin
      e_dig = 4'(1 << d); e_seg = m_active[d];
    end else begin
      e_dig = '0; e_seg = '0;
    end
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    int last = -1;
    f_bad = 0; f_fs = 0; f_gap_bad = 0; f_on_tot = 0; f_seg_or = '0;
    for (int d = 0; d < 4; d++) begin f_on[d] = 0; f_seg[d] = '0; end
    for (int i = 0; i < n; i++) begin
      tick();
      if (dut_vec() !== exp_vec()) begin
        if (f_bad == 0) begin f_got = dut_vec(); f_exp = exp_vec(); end
        f_bad++;
      end
      for (int d = 0; d < 4; d++)
        if (digitEnableOut === 4'(1 << d)) begin
          f_on[d]++; f_on_tot++; f_seg[d] = segmentEnableOut; f_seg_or |= segmentEnableOut;
        end
      if (frameStartOut === 1'b1) begin
        if (last >= 0 && i - last != FRAME) f_gap_bad++;
        last = i; f_fs++;
      end
    end
  endtask

  // advance to the last cycle of a frame so the next tick is a frame start
  task automatic sync();
    int n = 0;
    while ((m_t != FRAME - 1 || !m_run) && n <= 2 * FRAME) begin tick(); n++; end
    checks++;
    if (n > 2 * FRAME) begin
      errors++; $display("FAIL sync_timeout: waited %0d cycles, limit %0d", n, 2 * FRAME);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    repeat (3) tick();
    checks++;
    if (dut_vec() !== 15'h0001) begin
      errors++; $display("FAIL reset_state: got %h exp %h", dut_vec(), 15'h0001);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== 15'h0001) begin
      errors++; $display("FAIL idle_after_reset: got %h exp %h", dut_vec(), 15'h0001);
    end
  endtask

  task automatic test_scan();
    bright = 4'd15; en = 1'b1;
    tick();
    checks++;
    if (frameStartOut !== 1'b1) begin errors++; $display("FAIL first_frame_start: got %b exp 1", frameStartOut); end
    checks++;
    if (digitEnableOut !== 4'b0) begin errors++; $display("FAIL blank_at_start: got %b exp 0000", digitEnableOut); end
    sync();
    run_cycles(2 * FRAME);
    checks++;
    if (f_bad !== 0) begin errors++; $display("FAIL scan_model: %0d bad cycles, got %h exp %h", f_bad, f_got, f_exp); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (f_on[d] !== 192) begin errors++; $display("FAIL scan_on_digit%0d: got %0d exp 192", d, f_on[d]); end
    end
    checks++;
    if (f_fs !== 2 || f_gap_bad !== 0) begin
      errors++; $display("FAIL scan_frame_period: starts %0d exp 2, bad gaps %0d exp 0", f_fs, f_gap_bad);
    end
  endtask

  task automatic test_brightness();
    int first_half;
    bright = 4'd0; sync(); run_cycles(FRAME);
    checks++;
    if (f_on_tot !== 24 || f_on[0] !== 6) begin
      errors++; $display("FAIL bright0_on: got %0d/%0d exp 24/6", f_on_tot, f_on[0]);
    end
    checks++;
    if (f_bad !== 0) begin errors++; $display("FAIL bright0_model: %0d bad, got %h exp %h", f_bad, f_got, f_exp); end
    bright = 4'd7; sync(); run_cycles(FRAME);
    checks++;
    if (f_on_tot !== 192) begin errors++; $display("FAIL bright7_on: got %0d exp 192", f_on_tot); end
    sync(); run_cycles(FRAME / 2);
    first_half = f_on_tot;
    bright = 4'd15; run_cycles(FRAME / 2);
    checks++;
    if (first_half + f_on_tot !== 192) begin
      errors++; $display("FAIL bright_midframe: got %0d exp 192", first_half + f_on_tot);
    end
    run_cycles(FRAME);
    checks++;
    if (f_on_tot !== 384) begin errors++; $display("FAIL bright_next_frame: got %0d exp 384", f_on_tot); end
  endtask

  task automatic test_commit();
    int n = 0;
    bit held = 1;
    bright = 4'd15; sync(); run_cycles(120);
    wr_valid = 1'b1; wr_idx = 2'd2; wr_data = 8'h3F; tick(); wr_valid = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    checks++;
    if ({commitPendingOut, wrReadyOut} !== 2'b10) begin
      errors++; $display("FAIL commit_pending: got %b exp 10", {commitPendingOut, wrReadyOut});
    end
    while (frameStartOut !== 1'b1 && n < FRAME + 2) begin
      if ({commitPendingOut, wrReadyOut} !== 2'b10) held = 0;
      tick(); n++;
    end
    checks++;
    if (frameStartOut !== 1'b1) begin errors++; $display("FAIL commit_frame_timeout: no frame start in %0d cycles", n); end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL commit_pending_held: got dropped exp held"); end
    checks++;
    if ({commitPendingOut, wrReadyOut} !== 2'b01) begin
      errors++; $display("FAIL commit_clear_at_frame: got %b exp 01", {commitPendingOut, wrReadyOut});
    end
    run_cycles(FRAME);
    checks++;
    if (f_seg[2] !== 8'h3F || f_bad !== 0) begin
      errors++; $display("FAIL commit_digit2: got %h (bad %0d) exp 3f (bad 0)", f_seg[2], f_bad);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    sync(); run_cycles(50);
    commit = 1'b1; tick(); commit = 1'b0;
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 8'h06;
    while (wrReadyOut !== 1'b1 && n < FRAME + 2) begin tick(); n++; end
    checks++;
    if (n !== 350 || frameStartOut !== 1'b1) begin
      errors++; $display("FAIL held_write_ready: rose after %0d (fs %b) exp 350 (fs 1)", n, frameStartOut);
    end
    tick(); wr_valid = 1'b0;
    run_cycles(FRAME);
    checks++;
    if (f_seg[1] !== 8'h00 || f_bad !== 0) begin
      errors++; $display("FAIL held_write_shadow_only: got %h (bad %0d) exp 00 (bad 0)", f_seg[1], f_bad);
    end
    wr_valid = 1'b1; wr_idx = 2'd0; wr_data = 8'h5B; commit = 1'b1;
    tick(); wr_valid = 1'b0; commit = 1'b0;
    run_cycles(2 * FRAME);
    checks++;
    if ({f_seg[0], f_seg[1]} !== 16'h5B06 || f_bad !== 0) begin
      errors++; $display("FAIL same_cycle_commit: got %h%h (bad %0d) exp 5b06", f_seg[0], f_seg[1], f_bad);
    end
  endtask

  task automatic test_disable();
    sync(); run_cycles(10);
    checks++;
    if (digitEnableOut !== 4'b0001) begin errors++; $display("FAIL disable_pre_on: got %b exp 0001", digitEnableOut); end
    en = 1'b0; tick();
    checks++;
    if ({digitEnableOut, segmentEnableOut} !== 12'h000) begin
      errors++; $display("FAIL disable_off: got %h exp 000", {digitEnableOut, segmentEnableOut});
    end
    run_cycles(20);
    checks++;
    if (f_on_tot !== 0 || f_bad !== 0) begin
      errors++; $display("FAIL disable_idle: on %0d bad %0d exp 0 0", f_on_tot, f_bad);
    end
    en = 1'b1; tick();
    checks++;
    if (frameStartOut !== 1'b1) begin errors++; $display("FAIL reenable_frame_start: got %b exp 1", frameStartOut); end
    run_cycles(FRAME - 1);
    checks++;
    if (f_on[0] !== 96 || f_bad !== 0) begin
      errors++; $display("FAIL reenable_digit0: on %0d bad %0d exp 96 0", f_on[0], f_bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(999) != 0);
      bright   = 4'($urandom);
      wr_valid = ($urandom_range(2) == 0);
      wr_idx   = 2'($urandom);
      wr_data  = 8'($urandom);
      commit   = ($urandom_range(19) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    en = 1'b1; wr_valid = 1'b0; commit = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; bright = 4'd15;
    sync(); run_cycles(150);
    wr_valid = 1'b1; wr_idx = 2'd3; wr_data = 8'hFF; commit = 1'b1;
    tick(); wr_valid = 1'b0; commit = 1'b0;
    checks++;
    if (commitPendingOut !== 1'b1) begin errors++; $display("FAIL areset_pre_pending: got %b exp 1", commitPendingOut); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 15'h0001) begin errors++; $display("FAIL areset_async: got %h exp %h", dut_vec(), 15'h0001); end
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    run_cycles(2 * FRAME + 1);
    checks++;
    if (f_bad !== 0 || f_seg_or !== 8'h00 || f_on_tot !== 768) begin
      errors++; $display("FAIL areset_cleared: bad %0d seg %h on %0d exp 0 00 768", f_bad, f_seg_or, f_on_tot);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_commit();
    test_back_to_back();
    test_disable();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
